mau_arbiter: RTL

MAU_ARBITER -- requirements
Module: mau_arbiter

---
 rtl/mau_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mau_arbiter.sv
// mau_arbiter: round-robin arbiter that serialises NREQ requesters onto a
// single four-phase req/ack handshake with the MDL accounting unit (MAU).
// Each transaction latches the winner's payload, waits for the ack edge,
// waits for the ack to drop, then pulses done to the owner. Both handshake
// phases have a bounded wait.
module mau_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*6-1:0]  req_module_id,
  input  logic [NREQ*32-1:0] req_module_size,
  input  logic [NREQ-1:0]    req_consistent,
  output logic [NREQ-1:0]    done,
  output logic [31:0]        resp_cost,
  output logic               resp_err,
  output logic               mau_req,
  output logic [5:0]         mau_module_id,
  output logic [31:0]        mau_module_size,
  output logic               mau_consistent,
  input  logic [31:0]        mau_cost,
  input  logic               mau_ack,
  input  logic               mau_error,
  output logic               busy,
  output logic [2:0]         owner,
  output logic               timeout_flag,
  output logic [31:0]        served_count
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, DONE} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    owner_reg, owner_next;
  logic [2:0]    rr_ptr_reg, rr_ptr_next;
  logic [WW-1:0] wait_reg, wait_next, wait_inc;
  logic [31:0]   cost_reg, cost_next;
  logic          err_reg, err_next;
  logic          tflag_reg, tflag_next;
  logic [31:0]   served_reg, served_next;
  logic [5:0]    id_reg, id_next;
  logic [31:0]   size_reg, size_next;
  logic          cons_reg, cons_next;

  // Arbitration signals
  logic [NREQ-1:0] req_rot;
  logic [2:0]      pos;
  logic [3:0]      grant_sum;
  logic [2:0]      grant_idx;
  logic            grant_valid;
  logic [NREQ-1:0] grant_oh;
  logic [3:0]      owner_inc;
  logic [2:0]      rr_wrap;

  // Payload select signals
  logic [5:0]      id_masked   [NREQ];
  logic [31:0]     size_masked [NREQ];
  logic [NREQ-1:0] cons_masked;
  logic [5:0]      sel_id;
  logic [31:0]     sel_size;
  logic            sel_cons;

  // Rotate requests so bit 0 corresponds to the requester at rr_ptr.
  assign req_rot     = NREQ'({req, req} >> rr_ptr_reg);
  assign grant_valid = |req;

  // Lowest set bit of the rotated vector is the first requester at/after rr_ptr.
  always_comb begin
    pos = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pos = 3'(i);
    end
  end

  // Map the rotated position back to a requester index, modulo NREQ.
  always_comb begin
    grant_sum = {1'b0, rr_ptr_reg} + {1'b0, pos};
    if (grant_sum >= 4'(NREQ)) grant_sum = grant_sum - 4'(NREQ);
  end
  assign grant_idx = 3'(grant_sum);

  // Next round-robin pointer: one past the owner, wrapping at NREQ.
  assign owner_inc = {1'b0, owner_reg} + 4'd1;
  assign rr_wrap   = (owner_inc >= 4'(NREQ)) ? 3'd0 : 3'(owner_inc);

  assign wait_inc = wait_reg + WW'(1);

  // Per-requester one-hot grant, masked payload and done decode.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign grant_oh[gi]    = grant_valid && (grant_idx == 3'(gi));
      assign id_masked[gi]   = grant_oh[gi] ? req_module_id[6*gi +: 6] : 6'd0;
      assign size_masked[gi] = grant_oh[gi] ? req_module_size[32*gi +: 32] : 32'd0;
      assign cons_masked[gi] = grant_oh[gi] & req_consistent[gi];
      assign done[gi]        = (state_reg == DONE) && (owner_reg == 3'(gi));
    end
  endgenerate

  // OR-combine the masked payloads; at most one slice is non-zero.
  always_comb begin
    sel_id   = '0;
    sel_size = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_id   = sel_id | id_masked[i];
      sel_size = sel_size | size_masked[i];
    end
    sel_cons = |cons_masked;
  end

  // Next-state and datapath updates for the handshake FSM.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    wait_next   = wait_reg;
    cost_next   = cost_reg;
    err_next    = err_reg;
    tflag_next  = tflag_reg;
    served_next = served_reg;
    id_next     = id_reg;
    size_next   = size_reg;
    cons_next   = cons_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = ISSUE;
          owner_next = grant_idx;
          id_next    = sel_id;
          size_next  = sel_size;
          cons_next  = sel_cons;
          wait_next  = '0;
        end
      end
      ISSUE: begin
        if (mau_ack) begin
          // A real ack wins over a timeout landing on the same cycle.
          cost_next  = mau_cost;
          err_next   = mau_error;
          wait_next  = '0;
          state_next = RELEASE;
        end else if (wait_inc == WW'(TIMEOUT)) begin
          cost_next  = 32'hFFFF_FFFF;
          err_next   = 1'b1;
          tflag_next = 1'b1;
          wait_next  = wait_inc;
          state_next = DONE;
        end else begin
          wait_next = wait_inc;
        end
      end
      RELEASE: begin
        if (!mau_ack) begin
          state_next = DONE;
        end else if (wait_inc == WW'(TIMEOUT)) begin
          // Keep the captured response; only flag the stuck ack.
          tflag_next = 1'b1;
          wait_next  = wait_inc;
          state_next = DONE;
        end else begin
          wait_next = wait_inc;
        end
      end
      DONE: begin
        served_next = served_reg + 32'd1;
        rr_ptr_next = rr_wrap;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      wait_reg   <= '0;
      cost_reg   <= '0;
      err_reg    <= 1'b0;
      tflag_reg  <= 1'b0;
      served_reg <= '0;
      id_reg     <= '0;
      size_reg   <= '0;
      cons_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
      wait_reg   <= wait_next;
      cost_reg   <= cost_next;
      err_reg    <= err_next;
      tflag_reg  <= tflag_next;
      served_reg <= served_next;
      id_reg     <= id_next;
      size_reg   <= size_next;
      cons_reg   <= cons_next;
    end
  end

  assign mau_req         = (state_reg == ISSUE);
  assign busy            = (state_reg != IDLE);
  assign owner           = owner_reg;
  assign resp_cost       = cost_reg;
  assign resp_err        = err_reg;
  assign timeout_flag    = tflag_reg;
  assign served_count    = served_reg;
  assign mau_module_id   = id_reg;
  assign mau_module_size = size_reg;
  assign mau_consistent  = cons_reg;

endmodule
